// File: rtl/rtc_bus_responder.sv
// Bridges 68k bus cycles in the $DC0000-$DCFFFF window to one 16-bit SPI mode-0 frame each, terminated by DSACK0.
// Latency: strobe pin to DSACK0 low = 3 + 32*CLK_DIV clk cycles; DSACK0 high 3 cycles after AS rises, tristate 1 later.
// Backpressure: one transaction in flight; hits outside IDLE are ignored until AS has been seen high.
module rtc_bus_responder #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] A,
    input  logic        RW,
    input  logic        AS,
    input  logic        DS,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        DSACK0,
    output logic        DSACK1,
    output logic        DSACK_oe,
    output logic        SPI2_CLK,
    output logic        SPI2_MOSI,
    input  logic        SPI2_MISO,
    output logic        SPI2_CS
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACK,
        WAIT_NEG
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic        as_meta_q, as_meta_d;
    logic        as_s_q, as_s_d;
    logic        ds_meta_q, ds_meta_d;
    logic        ds_s_q, ds_s_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [4:0]  edge_cnt_q, edge_cnt_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        gap_q, gap_d;
    logic        dsack0_q, dsack0_d;
    logic        dsack_oe_q, dsack_oe_d;
    logic        d_oe_q, d_oe_d;
    logic [7:0]  d_out_q, d_out_d;

    logic hit;
    logic unused_addr_bits;

    // Registers alias across A[15:6] and A[1:0].
    assign unused_addr_bits = ^{A[15:6], A[1:0]};
    assign hit = !as_s_q && !ds_s_q && (A[23:16] == 8'hDC);

    always_comb begin
        as_meta_d  = AS;
        as_s_d     = as_meta_q;
        ds_meta_d  = DS;
        ds_s_d     = ds_meta_q;
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rw_d       = rw_q;
        gap_d      = gap_q;
        dsack0_d   = dsack0_q;
        dsack_oe_d = dsack_oe_q;
        d_oe_d     = d_oe_q;
        d_out_d    = d_out_q;

        case (state_q)
            IDLE: begin
                // After an aborted frame, hold CS high one extra cycle before accepting a new hit.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (hit) begin
                    state_d    = SHIFT;
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;
                    div_cnt_d  = 4'd0;
                    edge_cnt_d = 5'd0;
                    rw_d       = RW;
                    tx_d       = {RW, 3'b000, A[5:2], (RW ? 8'h00 : D_in)};
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = 4'd0;
                    sclk_d     = !sclk_q;
                    edge_cnt_d = edge_cnt_q + 5'd1;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], SPI2_MISO};
                    end else begin
                        tx_d = {tx_q[14:0], 1'b0};
                        if (edge_cnt_q == 5'd31) begin
                            cs_n_d     = 1'b1;
                            edge_cnt_d = 5'd0;
                            if (!as_s_q) begin
                                state_d    = ACK;
                                dsack_oe_d = 1'b1;
                                dsack0_d   = 1'b0;
                                d_oe_d     = rw_q;
                                d_out_d    = rw_q ? rx_q : 8'h00;
                            end else begin
                                state_d = IDLE;
                                gap_d   = 1'b1;
                            end
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
            end
            ACK: begin
                if (as_s_q) begin
                    state_d  = WAIT_NEG;
                    dsack0_d = 1'b1;
                    d_oe_d   = 1'b0;
                    d_out_d  = 8'h00;
                end
            end
            WAIT_NEG: begin
                state_d    = IDLE;
                dsack_oe_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            as_meta_q  <= 1'b1;
            as_s_q     <= 1'b1;
            ds_meta_q  <= 1'b1;
            ds_s_q     <= 1'b1;
            div_cnt_q  <= 4'd0;
            edge_cnt_q <= 5'd0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_q       <= 16'h0000;
            rx_q       <= 8'h00;
            rw_q       <= 1'b0;
            gap_q      <= 1'b0;
            dsack0_q   <= 1'b1;
            dsack_oe_q <= 1'b0;
            d_oe_q     <= 1'b0;
            d_out_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            as_meta_q  <= as_meta_d;
            as_s_q     <= as_s_d;
            ds_meta_q  <= ds_meta_d;
            ds_s_q     <= ds_s_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rw_q       <= rw_d;
            gap_q      <= gap_d;
            dsack0_q   <= dsack0_d;
            dsack_oe_q <= dsack_oe_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
        end
    end

    assign SPI2_CS   = cs_n_q;
    assign SPI2_CLK  = sclk_q;
    assign SPI2_MOSI = tx_q[15];
    assign DSACK0    = dsack0_q;
    assign DSACK1    = 1'b1;
    assign DSACK_oe  = dsack_oe_q;
    assign D_oe      = d_oe_q;
    assign D_out     = d_out_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: randomized bus accesses against a frame/timing reference model and an SPI slave model.
module tb_rtc_bus_responder;

    localparam int DIV     = 2;
    localparam int FRAME   = 32 * DIV;
    localparam int HIT_LAT = 3;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [23:0] A    = 24'h000000;
    logic        RW   = 1'b1;
    logic        AS   = 1'b1;
    logic        DS   = 1'b1;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe, DSACK0, DSACK1, DSACK_oe, SPI2_CLK, SPI2_MOSI, SPI2_CS;
    logic        SPI2_MISO = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          t0     = 0;
    logic [15:0] slave_word = 16'h0000;

    logic        cs_prev = 1'b1, sclk_prev = 1'b0, dsack0_prev = 1'b1;
    int          n_cs_falls = 0, n_frames = 0, n_dsack = 0, n_oe_cyc = 0, n_doe_cyc = 0, n_dsack1_bad = 0;
    int          cs_fall_cyc = 0, cs_rise_cyc = 0, dsack_cyc = 0, fall_cnt = 0, mosi_cnt = 0;
    logic [15:0] mosi_sh = 16'h0000;
    logic        mosi_first = 1'b0;
    logic [7:0]  dsack_dout = 8'h00;
    logic        dsack_doe = 1'b0;

    rtc_bus_responder #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .RW       (RW),
        .AS       (AS),
        .DS       (DS),
        .D_in     (D_in),
        .D_out    (D_out),
        .D_oe     (D_oe),
        .DSACK0   (DSACK0),
        .DSACK1   (DSACK1),
        .DSACK_oe (DSACK_oe),
        .SPI2_CLK (SPI2_CLK),
        .SPI2_MOSI(SPI2_MOSI),
        .SPI2_MISO(SPI2_MISO),
        .SPI2_CS  (SPI2_CS)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus/SPI observer plus a mode-0 slave that shifts slave_word out MSB first.
    always @(negedge clk) begin
        if (cs_prev === 1'b1 && SPI2_CS === 1'b0) begin
            cs_fall_cyc = cyc;
            n_cs_falls++;
            mosi_first = SPI2_MOSI;
            mosi_sh    = 16'h0000;
            mosi_cnt   = 0;
            fall_cnt   = 0;
        end
        if (cs_prev === 1'b0 && SPI2_CS === 1'b1) begin
            cs_rise_cyc = cyc;
            n_frames++;
        end
        if (SPI2_CS === 1'b0 && sclk_prev === 1'b0 && SPI2_CLK === 1'b1) begin
            mosi_sh = {mosi_sh[14:0], SPI2_MOSI};
            mosi_cnt++;
        end
        if (SPI2_CS === 1'b0 && sclk_prev === 1'b1 && SPI2_CLK === 1'b0) fall_cnt++;
        if (DSACK_oe === 1'b1) n_oe_cyc++;
        if (D_oe === 1'b1) n_doe_cyc++;
        if (DSACK_oe === 1'b1 && DSACK0 === 1'b0 && dsack0_prev === 1'b1) begin
            dsack_cyc  = cyc;
            n_dsack++;
            dsack_dout = D_out;
            dsack_doe  = D_oe;
        end
        if (DSACK1 !== 1'b1 && !rst) n_dsack1_bad++;
        SPI2_MISO   = (fall_cnt < 16) ? slave_word[4'(15 - fall_cnt)] : 1'b0;
        cs_prev     = SPI2_CS;
        sclk_prev   = SPI2_CLK;
        dsack0_prev = DSACK0;
    end

    function automatic logic [15:0] model_frame(input logic [23:0] addr, input logic rd, input logic [7:0] wd);
        int reg_idx, cmd, dat;
        reg_idx = int'(addr / 4) % 16;
        cmd     = (rd ? 128 : 0) + reg_idx;
        dat     = rd ? 0 : int'(wd);
        return 16'(cmd * 256 + dat);
    endfunction

    function automatic bit model_hit(input logic [23:0] addr);
        return (int'(addr) / 65536) == 220;
    endfunction

    task automatic start_access(input logic [23:0] addr, input logic rd, input logic [7:0] wd, input logic [7:0] sb);
        A          = addr;
        RW         = rd;
        D_in       = wd;
        slave_word = {8'($urandom), sb};
        @(posedge clk);
        #1;
        AS = 1'b0;
        DS = 1'b0;
        t0 = cyc;
    endtask

    task automatic end_access();
        @(posedge clk);
        #1;
        AS = 1'b1;
        DS = 1'b1;
    endtask

    task automatic wait_dsack(input int ds0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (n_dsack != ds0) ok = 1'b1;
        end
    endtask

    task automatic wait_cs_fall(input int f0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (n_cs_falls != f0) ok = 1'b1;
        end
    endtask

    task automatic wait_cs_rise(input int r0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (n_frames != r0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (SPI2_CS !== 1'b1)   begin errors++; $display("FAIL reset_cs got=%b exp=1", SPI2_CS); end
        checks++; if (SPI2_CLK !== 1'b0)  begin errors++; $display("FAIL reset_sclk got=%b exp=0", SPI2_CLK); end
        checks++; if (SPI2_MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", SPI2_MOSI); end
        checks++; if (DSACK_oe !== 1'b0)  begin errors++; $display("FAIL reset_dsack_oe got=%b exp=0", DSACK_oe); end
        checks++; if (DSACK0 !== 1'b1)    begin errors++; $display("FAIL reset_dsack0 got=%b exp=1", DSACK0); end
        checks++; if (DSACK1 !== 1'b1)    begin errors++; $display("FAIL reset_dsack1 got=%b exp=1", DSACK1); end
        checks++; if (D_oe !== 1'b0)      begin errors++; $display("FAIL reset_d_oe got=%b exp=0", D_oe); end
        checks++; if (D_out !== 8'h00)    begin errors++; $display("FAIL reset_d_out got=%h exp=00", D_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_write();
        logic [23:0] addr;
        logic [7:0]  wd;
        logic [15:0] exp_frame;
        int          ds0, doe0;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin addr = 24'hDC0014; wd = 8'hA5; end
            else begin addr = {8'hDC, 16'($urandom)}; wd = 8'($urandom); end
            exp_frame = model_frame(addr, 1'b0, wd);
            ds0  = n_dsack;
            doe0 = n_doe_cyc;
            start_access(addr, 1'b0, wd, 8'($urandom));
            wait_dsack(ds0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL wr_dsack_timeout addr=%h got=none exp=dsack", addr); end
            checks++; if (cs_fall_cyc - t0 !== HIT_LAT) begin errors++; $display("FAIL wr_cs_latency got=%0d exp=%0d", cs_fall_cyc - t0, HIT_LAT); end
            checks++; if (cs_rise_cyc - cs_fall_cyc !== FRAME) begin errors++; $display("FAIL wr_frame_len got=%0d exp=%0d", cs_rise_cyc - cs_fall_cyc, FRAME); end
            checks++; if (dsack_cyc - t0 !== HIT_LAT + FRAME) begin errors++; $display("FAIL wr_dsack_latency got=%0d exp=%0d", dsack_cyc - t0, HIT_LAT + FRAME); end
            checks++; if (mosi_sh !== exp_frame || mosi_cnt !== 16) begin errors++; $display("FAIL wr_mosi got=%h/%0d exp=%h/16", mosi_sh, mosi_cnt, exp_frame); end
            checks++; if (mosi_first !== exp_frame[15]) begin errors++; $display("FAIL wr_mosi_first got=%b exp=%b", mosi_first, exp_frame[15]); end
            end_access();
            repeat (3) @(posedge clk);
            @(negedge clk);
            checks++; if (DSACK0 !== 1'b1 || DSACK_oe !== 1'b1) begin errors++; $display("FAIL wr_release_high got=%b/%b exp=1/1", DSACK0, DSACK_oe); end
            @(negedge clk);
            checks++; if (DSACK_oe !== 1'b0) begin errors++; $display("FAIL wr_release_tristate got=%b exp=0", DSACK_oe); end
            checks++; if (n_doe_cyc - doe0 !== 0) begin errors++; $display("FAIL wr_d_oe got=%0d exp=0 cycles", n_doe_cyc - doe0); end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_read();
        logic [23:0] addr;
        logic [7:0]  sb;
        logic [15:0] exp_frame;
        int          ds0;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin addr = 24'hDC003C; sb = 8'h3C; end
            else begin addr = {8'hDC, 16'($urandom)}; sb = 8'($urandom); end
            exp_frame = model_frame(addr, 1'b1, 8'h00);
            ds0 = n_dsack;
            start_access(addr, 1'b1, 8'($urandom), sb);
            wait_dsack(ds0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rd_dsack_timeout addr=%h got=none exp=dsack", addr); end
            checks++; if (mosi_sh !== exp_frame) begin errors++; $display("FAIL rd_mosi got=%h exp=%h", mosi_sh, exp_frame); end
            checks++; if (dsack_cyc - t0 !== HIT_LAT + FRAME) begin errors++; $display("FAIL rd_dsack_latency got=%0d exp=%0d", dsack_cyc - t0, HIT_LAT + FRAME); end
            checks++; if (dsack_dout !== sb || dsack_doe !== 1'b1) begin errors++; $display("FAIL rd_data got=%h/%b exp=%h/1", dsack_dout, dsack_doe, sb); end
            end_access();
            repeat (3) @(posedge clk);
            @(negedge clk);
            checks++; if (DSACK0 !== 1'b1 || D_oe !== 1'b0 || DSACK_oe !== 1'b1) begin errors++; $display("FAIL rd_release_high got=%b/%b/%b exp=1/0/1", DSACK0, D_oe, DSACK_oe); end
            @(negedge clk);
            checks++; if (DSACK_oe !== 1'b0) begin errors++; $display("FAIL rd_release_tristate got=%b exp=0", DSACK_oe); end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_miss();
        logic [23:0] addr;
        int          f0, oe0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) addr = 24'hDB0000;
            else if (i == 1) addr = 24'hDD0004;
            else begin
                addr = 24'($urandom);
                if (addr[23:16] == 8'hDC) addr[23:16] = 8'h5A;
            end
            f0  = n_cs_falls;
            oe0 = n_oe_cyc;
            start_access(addr, 1'($urandom), 8'($urandom), 8'($urandom));
            repeat (100) @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (n_cs_falls - f0 !== (model_hit(addr) ? 1 : 0)) begin errors++; $display("FAIL miss_cs addr=%h got=%0d exp=0 frames", addr, n_cs_falls - f0); end
            checks++; if (n_oe_cyc - oe0 !== 0) begin errors++; $display("FAIL miss_dsack_oe addr=%h got=%0d exp=0 cycles", addr, n_oe_cyc - oe0); end
            end_access();
            repeat (4) @(posedge clk);
        end
    endtask

    task automatic test_abort();
        int f0, r0, ds0, oe0;
        bit ok;
        f0  = n_cs_falls;
        r0  = n_frames;
        ds0 = n_dsack;
        oe0 = n_oe_cyc;
        start_access(24'hDC0020, 1'b0, 8'($urandom), 8'($urandom));
        wait_cs_fall(f0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_start_timeout got=none exp=cs_fall"); end
        repeat (20) @(posedge clk);
        #1;
        AS = 1'b1;
        DS = 1'b1;
        wait_cs_rise(r0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_end_timeout got=none exp=cs_rise"); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (cs_rise_cyc - cs_fall_cyc !== FRAME) begin errors++; $display("FAIL abort_frame_len got=%0d exp=%0d", cs_rise_cyc - cs_fall_cyc, FRAME); end
        checks++; if (n_oe_cyc - oe0 !== 0 || n_dsack - ds0 !== 0) begin errors++; $display("FAIL abort_dsack got=%0d/%0d exp=0/0", n_oe_cyc - oe0, n_dsack - ds0); end
        ds0 = n_dsack;
        start_access(24'hDC0030, 1'b1, 8'($urandom), 8'h69);
        wait_dsack(ds0, ok);
        checks++; if (!ok || dsack_cyc - t0 !== HIT_LAT + FRAME) begin errors++; $display("FAIL abort_next_access got=%0d exp=%0d", dsack_cyc - t0, HIT_LAT + FRAME); end
        checks++; if (dsack_dout !== 8'h69 || mosi_sh !== model_frame(24'hDC0030, 1'b1, 8'h00)) begin errors++; $display("FAIL abort_next_data got=%h/%h exp=69/%h", dsack_dout, mosi_sh, model_frame(24'hDC0030, 1'b1, 8'h00)); end
        end_access();
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int f0, ds0;
        bit ok;
        f0 = n_cs_falls;
        start_access(24'hDC0004, 1'b0, 8'h5E, 8'($urandom));
        wait_cs_fall(f0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_start_timeout got=none exp=cs_fall"); end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        AS  = 1'b1;
        DS  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (SPI2_CS !== 1'b1 || SPI2_CLK !== 1'b0 || DSACK_oe !== 1'b0) begin errors++; $display("FAIL rstmid_abort got=%b/%b/%b exp=1/0/0", SPI2_CS, SPI2_CLK, DSACK_oe); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        ds0 = n_dsack;
        start_access(24'hDC0018, 1'b1, 8'($urandom), 8'hC3);
        wait_dsack(ds0, ok);
        checks++; if (!ok || dsack_cyc - t0 !== HIT_LAT + FRAME || dsack_dout !== 8'hC3) begin errors++; $display("FAIL rstmid_next got=%0d/%h exp=%0d/c3", dsack_cyc - t0, dsack_dout, HIT_LAT + FRAME); end
        end_access();
        repeat (6) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] sb1, sb2;
        int         f0, ds0;
        bit         ok;
        sb1 = 8'($urandom);
        sb2 = 8'($urandom);
        f0  = n_cs_falls;
        ds0 = n_dsack;
        start_access(24'hDC0008, 1'b1, 8'($urandom), sb1);
        wait_dsack(ds0, ok);
        checks++; if (!ok || dsack_dout !== sb1) begin errors++; $display("FAIL b2b_first got=%h exp=%h", dsack_dout, sb1); end
        repeat (100) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (n_cs_falls - f0 !== 1 || DSACK0 !== 1'b0) begin errors++; $display("FAIL b2b_hold got=%0d/%b exp=1/0", n_cs_falls - f0, DSACK0); end
        slave_word = {8'($urandom), sb2};
        @(posedge clk);
        #1;
        AS = 1'b1;
        DS = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        AS = 1'b0;
        DS = 1'b0;
        wait_dsack(ds0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got=none exp=dsack"); end
        checks++; if (n_cs_falls - f0 !== 2 || n_dsack - ds0 !== 2 || dsack_dout !== sb2) begin errors++; $display("FAIL b2b_second got=%0d/%0d/%h exp=2/2/%h", n_cs_falls - f0, n_dsack - ds0, dsack_dout, sb2); end
        end_access();
        repeat (6) @(posedge clk);
        checks++; if (n_dsack1_bad !== 0) begin errors++; $display("FAIL dsack1_asserted got=%0d exp=0 cycles", n_dsack1_bad); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_miss();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
